// File: rtl/waterfall_pattern_monitor.sv
// Receive-side checker for a running-light (waterfall) LED bus.
// On each sample strobe the bus is decoded into a lit position, a run
// direction and a lap count; multi-hot patterns and non-adjacent jumps
// raise a sticky error flag that only err_clr removes.
//
// Handshake: there is no valid/ready pair here. sample_en is a one-cycle
// qualifier: led_in is evaluated only on an edge where sample_en=1, and
// the producer never waits. All outputs are registered. step is a
// one-cycle pulse, and every other output holds between strobes.
module waterfall_pattern_monitor #(
    parameter int WIDTH    = 8,
    parameter int LAP_W    = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sample_en,
    input  logic [WIDTH-1:0]         led_in,
    input  logic                     err_clr,
    output logic [$clog2(WIDTH)-1:0] pos,
    output logic                     pos_valid,
    output logic [1:0]               dir,
    output logic                     step,
    output logic [LAP_W-1:0]         lap_cnt,
    output logic                     err,
    output logic [2:0]               fsm_state
);

    localparam int PW = $clog2(WIDTH);
    localparam int HW = $clog2(HOLD_MAX + 1);
    localparam logic [PW-1:0] LAST_IDX = PW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_SYNC  = 3'd0,
        S_FIRST = 3'd1,
        S_LEFT  = 3'd2,
        S_RIGHT = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t          state;
    logic [HW-1:0]   hold_cnt;

    logic            is_zero;
    logic            is_multi;
    logic            is_one;
    logic [PW-1:0]   hot_idx;
    logic [PW-1:0]   p_inc;
    logic [PW-1:0]   p_dec;
    logic            tracking;
    logic            go_left;
    logic            go_right;
    logic            same_pos;
    logic            jump;
    logic            err_set;

    assign fsm_state = state;

    // Classify the sampled pattern and compare it with the previous position.
    always_comb begin
        is_zero  = (led_in == '0);
        is_multi = ($countones(led_in) > 1);
        is_one   = !is_zero && !is_multi;
        hot_idx  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (led_in[i]) hot_idx = PW'(i);
        end
        p_inc    = (pos == LAST_IDX) ? '0 : pos + PW'(1);
        p_dec    = (pos == '0) ? LAST_IDX : pos - PW'(1);
        tracking = is_one && (state != S_SYNC);
        go_left  = tracking && (hot_idx == p_inc);
        go_right = tracking && (hot_idx == p_dec);
        same_pos = tracking && (hot_idx == pos);
        jump     = tracking && !go_left && !go_right && !same_pos;
        err_set  = sample_en && (is_multi || jump);
    end

    // Decode FSM with registered outputs; err is sticky with set over clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_SYNC;
            hold_cnt  <= '0;
            pos       <= '0;
            pos_valid <= 1'b0;
            dir       <= 2'b00;
            step      <= 1'b0;
            lap_cnt   <= '0;
            err       <= 1'b0;
        end else begin
            step <= 1'b0;
            err  <= err_set | (err & ~err_clr);
            if (sample_en) begin
                if (!is_one) begin
                    // Blank or multi-hot: lose lock, keep the last pos value.
                    pos_valid <= 1'b0;
                    state     <= S_SYNC;
                    dir       <= 2'b00;
                    hold_cnt  <= '0;
                end else begin
                    pos       <= hot_idx;
                    pos_valid <= 1'b1;
                    if (state == S_SYNC) begin
                        state    <= S_FIRST;
                        dir      <= 2'b00;
                        hold_cnt <= '0;
                    end else if (go_left) begin
                        state    <= S_LEFT;
                        dir      <= 2'b01;
                        step     <= 1'b1;
                        hold_cnt <= '0;
                        if (pos == LAST_IDX) lap_cnt <= lap_cnt + LAP_W'(1);
                    end else if (go_right) begin
                        state    <= S_RIGHT;
                        dir      <= 2'b10;
                        step     <= 1'b1;
                        hold_cnt <= '0;
                        if (pos == '0) lap_cnt <= lap_cnt + LAP_W'(1);
                    end else if (same_pos) begin
                        if (int'(hold_cnt) < HOLD_MAX) hold_cnt <= hold_cnt + HW'(1);
                        if (int'(hold_cnt) >= HOLD_MAX - 1) begin
                            state <= S_STOP;
                            dir   <= 2'b11;
                        end
                    end else begin
                        // Illegal jump: restart tracking from the new position.
                        state    <= S_FIRST;
                        dir      <= 2'b00;
                        hold_cnt <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_waterfall_pattern_monitor.sv
// Table-driven bench for waterfall_pattern_monitor: each record holds the
// inputs for one clock and the outputs expected just after that edge.
module tb_waterfall_pattern_monitor;

    localparam int WIDTH = 8;
    localparam int LAP_W = 8;

    logic             clk;
    logic             rst_n;
    logic             sample_en;
    logic [WIDTH-1:0] led_in;
    logic             err_clr;
    logic [2:0]       pos;
    logic             pos_valid;
    logic [1:0]       dir;
    logic             step;
    logic [LAP_W-1:0] lap_cnt;
    logic             err;
    logic [2:0]       fsm_state;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic             se;
        logic [WIDTH-1:0] led;
        logic             clr;
        logic [2:0]       e_pos;
        logic             e_pv;
        logic [1:0]       e_dir;
        logic             e_step;
        logic [LAP_W-1:0] e_lap;
        logic             e_err;
    } vec_t;

    vec_t vecs[$];

    waterfall_pattern_monitor #(.WIDTH(WIDTH), .LAP_W(LAP_W), .HOLD_MAX(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sample_en (sample_en),
        .led_in    (led_in),
        .err_clr   (err_clr),
        .pos       (pos),
        .pos_valid (pos_valid),
        .dir       (dir),
        .step      (step),
        .lap_cnt   (lap_cnt),
        .err       (err),
        .fsm_state (fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec=%0d actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [2:0] p, input logic pv, input logic [1:0] d,
                             input logic s, input logic [LAP_W-1:0] l, input logic e);
        check("pos",       idx, 32'(pos),       32'(p));
        check("pos_valid", idx, 32'(pos_valid), 32'(pv));
        check("dir",       idx, 32'(dir),       32'(d));
        check("step",      idx, 32'(step),      32'(s));
        check("lap_cnt",   idx, 32'(lap_cnt),   32'(l));
        check("err",       idx, 32'(err),       32'(e));
    endtask

    task automatic add(input logic se, input logic [WIDTH-1:0] led, input logic clr,
                       input logic [2:0] p, input logic pv, input logic [1:0] d,
                       input logic s, input logic [LAP_W-1:0] l, input logic e);
        vec_t v;
        v.se = se; v.led = led; v.clr = clr;
        v.e_pos = p; v.e_pv = pv; v.e_dir = d; v.e_step = s; v.e_lap = l; v.e_err = e;
        vecs.push_back(v);
    endtask

    // driver: drive on the falling edge, compare 1 time unit after the rising edge
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        sample_en = v.se;
        led_in    = v.led;
        err_clr   = v.clr;
        @(posedge clk);
        #1;
        check_all(idx, v.e_pos, v.e_pv, v.e_dir, v.e_step, v.e_lap, v.e_err);
    endtask

    initial begin
        // Left run with wrap: 7 -> 0 counts a lap.
        add(1, 8'h01, 0, 3'd0, 1, 2'b00, 0, 8'd0, 0);
        for (int i = 1; i < 8; i++) add(1, 8'(1 << i), 0, 3'(i), 1, 2'b01, 1, 8'd0, 0);
        add(1, 8'h01, 0, 3'd0, 1, 2'b01, 1, 8'd1, 0);
        // Blank sample resynchronises without error; pos keeps its value.
        add(1, 8'h00, 0, 3'd0, 0, 2'b00, 0, 8'd1, 0);
        // Right run with wrap: 0 -> 7 counts a lap.
        add(1, 8'h80, 0, 3'd7, 1, 2'b00, 0, 8'd1, 0);
        for (int i = 6; i >= 0; i--) add(1, 8'(1 << i), 0, 3'(i), 1, 2'b10, 1, 8'd1, 0);
        add(1, 8'h80, 0, 3'd7, 1, 2'b10, 1, 8'd2, 0);
        // Gated strobe: led_in changes, outputs hold, step drops.
        add(0, 8'h55, 0, 3'd7, 1, 2'b10, 0, 8'd2, 0);
        add(1, 8'h00, 0, 3'd7, 0, 2'b00, 0, 8'd2, 0);
        // Hold: first sample, 15 repeats unchanged, 16th repeat stops, 17th stays stopped.
        add(1, 8'h08, 0, 3'd3, 1, 2'b00, 0, 8'd2, 0);
        for (int i = 1; i <= 15; i++) add(1, 8'h08, 0, 3'd3, 1, 2'b00, 0, 8'd2, 0);
        add(1, 8'h08, 0, 3'd3, 1, 2'b11, 0, 8'd2, 0);
        add(1, 8'h08, 0, 3'd3, 1, 2'b11, 0, 8'd2, 0);
        add(1, 8'h10, 0, 3'd4, 1, 2'b01, 1, 8'd2, 0);
        // Reversal after a left step is legal.
        add(1, 8'h08, 0, 3'd3, 1, 2'b10, 1, 8'd2, 0);
        add(1, 8'h00, 0, 3'd3, 0, 2'b00, 0, 8'd2, 0);
        // Jump 01 -> 08.
        add(1, 8'h01, 0, 3'd0, 1, 2'b00, 0, 8'd2, 0);
        add(1, 8'h08, 0, 3'd3, 1, 2'b00, 0, 8'd2, 1);
        // Multi-hot.
        add(1, 8'h18, 0, 3'd3, 0, 2'b00, 0, 8'd2, 1);
        // err_clr with a multi-hot sample: set wins. Then clear alone.
        add(1, 8'h05, 1, 3'd3, 0, 2'b00, 0, 8'd2, 1);
        add(0, 8'h05, 1, 3'd3, 0, 2'b00, 0, 8'd2, 0);
        add(0, 8'h20, 0, 3'd3, 0, 2'b00, 0, 8'd2, 0);
        // Error again, then gated change and blank sample leave err set.
        add(1, 8'h01, 0, 3'd0, 1, 2'b00, 0, 8'd2, 0);
        add(1, 8'h04, 0, 3'd2, 1, 2'b00, 0, 8'd2, 1);
        add(0, 8'h02, 0, 3'd2, 1, 2'b00, 0, 8'd2, 1);
        add(1, 8'h00, 0, 3'd2, 0, 2'b00, 0, 8'd2, 1);
        // Jump together with err_clr: set wins.
        add(1, 8'h01, 0, 3'd0, 1, 2'b00, 0, 8'd2, 1);
        add(1, 8'h40, 1, 3'd6, 1, 2'b00, 0, 8'd2, 1);

        rst_n     = 1'b0;
        sample_en = 1'b0;
        led_in    = '0;
        err_clr   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all(-1, 3'd0, 0, 2'b00, 0, 8'd0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Asynchronous reset mid-run with an active strobe clears outputs at once.
        @(negedge clk);
        sample_en = 1'b1;
        led_in    = 8'h80;
        err_clr   = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_all(-2, 3'd0, 0, 2'b00, 0, 8'd0, 0);
        @(posedge clk);
        #1;
        check_all(-3, 3'd0, 0, 2'b00, 0, 8'd0, 0);
        check("fsm_state", -3, 32'(fsm_state), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        led_in = 8'h02;
        @(posedge clk);
        #1;
        check_all(-4, 3'd1, 1, 2'b00, 0, 8'd0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
